// File: rtl/sync_level_debounce_if.sv
// Signal bundle between the clk_b-side synchronizer consumer and its status/event users.
interface sync_level_debounce_if #(
  parameter int CNT_W = 8
);
  logic             in_sync;
  logic             cnt_clr;
  logic             level_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] edge_cnt;
  logic             cnt_sat;

  modport master (
    output in_sync, cnt_clr,
    input  level_out, rise_pulse, fall_pulse, edge_cnt, cnt_sat
  );

  modport slave (
    input  in_sync, cnt_clr,
    output level_out, rise_pulse, fall_pulse, edge_cnt, cnt_sat
  );
endinterface

// File: rtl/sync_level_debounce.sv
// Level debouncer for an already-synchronized input: accepts a new level after
// STABLE_CYCLES equal samples, emits rise/fall pulses and a saturating edge count.
module sync_level_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 clk_b,
  input  logic                 rst_b,
  sync_level_debounce_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - CNT_W'(1);

  typedef enum logic [1:0] {S_LO, S_CHK_HI, S_HI, S_CHK_LO} state_t;

  state_t           state;
  logic [SW-1:0]    stab;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             rise_evt;
  logic             fall_evt;

  // With STABLE_CYCLES=1 the stable states accept directly and the check states are never entered.
  always_comb begin
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    case (state)
      S_LO:     rise_evt = bus.in_sync && (STABLE_CYCLES == 1);
      S_CHK_HI: rise_evt = bus.in_sync && (stab == STAB_LAST);
      S_HI:     fall_evt = !bus.in_sync && (STABLE_CYCLES == 1);
      S_CHK_LO: fall_evt = !bus.in_sync && (stab == STAB_LAST);
    endcase
  end

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      state   <= S_LO;
      stab    <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= rise_evt;
      fall_q <= fall_evt;
      if (rise_evt)
        level_q <= 1'b1;
      else if (fall_evt)
        level_q <= 1'b0;

      case (state)
        S_LO:
          if (bus.in_sync) begin
            if (rise_evt) begin
              state <= S_HI;
            end else begin
              state <= S_CHK_HI;
              stab  <= SW'(1);
            end
          end
        S_CHK_HI:
          if (!bus.in_sync) begin
            state <= S_LO;
            stab  <= '0;
          end else if (rise_evt) begin
            state <= S_HI;
            stab  <= '0;
          end else begin
            stab <= stab + SW'(1);
          end
        S_HI:
          if (!bus.in_sync) begin
            if (fall_evt) begin
              state <= S_LO;
            end else begin
              state <= S_CHK_LO;
              stab  <= SW'(1);
            end
          end
        S_CHK_LO:
          if (bus.in_sync) begin
            state <= S_HI;
            stab  <= '0;
          end else if (fall_evt) begin
            state <= S_LO;
            stab  <= '0;
          end else begin
            stab <= stab + SW'(1);
          end
      endcase
    end
  end

  // A clear coinciding with an accepted edge keeps that edge as the first new count.
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (bus.cnt_clr) begin
      cnt_q <= (rise_evt || fall_evt) ? CNT_W'(1) : '0;
      sat_q <= 1'b0;
    end else if ((rise_evt || fall_evt) && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
      sat_q <= (cnt_q == CNT_PRE);
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.edge_cnt   = cnt_q;
  assign bus.cnt_sat    = sat_q;
endmodule
